// File: rtl/parity_mem_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : parity_mem_pkg                                               |
// | Purpose : Shared constants, word typedefs and the byte-parity helper   |
// |           for the parity-protected memory.                             |
// | Ports   : none (package)                                               |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package parity_mem_pkg;

   // Default geometry; instances may override DATA_W, so these typedefs
   // describe the default-width word only.
   localparam int unsigned DATA_W_DFLT = 8;
   localparam int unsigned NB          = DATA_W_DFLT / 8;

   typedef logic [DATA_W_DFLT-1:0] data_t;
   typedef logic [NB-1:0]          par_t;

   // Stored / returned word layout: parity bits above the data.
   typedef struct packed {
      par_t  par;
      data_t data;
   } word_t;

   // Even parity of one byte: XOR of all its bits.
   function automatic logic byte_parity(input logic [7:0] b);
      return ^b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/parity_mem_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : parity_mem_if                                                |
// | Purpose : Access bus of the parity-protected memory.                   |
// | Ports   : none; signals write/read/address/data_in/inj_err (master     |
// |           drives) and data_out/rd_valid/parity_err/addr_err/uninit/    |
// |           err_count (slave drives).                                    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface parity_mem_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned CNT_W  = 8
);
   logic                       write;
   logic                       read;
   logic [ADDR_W-1:0]          address;
   logic [DATA_W-1:0]          data_in;
   logic                       inj_err;
   logic [DATA_W+DATA_W/8-1:0] data_out;
   logic                       rd_valid;
   logic                       parity_err;
   logic                       addr_err;
   logic                       uninit;
   logic [CNT_W-1:0]           err_count;

   modport master (
      output write, read, address, data_in, inj_err,
      input  data_out, rd_valid, parity_err, addr_err, uninit, err_count
   );

   modport slave (
      input  write, read, address, data_in, inj_err,
      output data_out, rd_valid, parity_err, addr_err, uninit, err_count
   );
endinterface
`default_nettype wire

// File: rtl/parity_mem_parity_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : parity_gen                                                   |
// | Purpose : Per-byte even-parity generator.                              |
// | Ports   : data_i [DATA_W]   - data word                                |
// |           par_o  [DATA_W/8] - bit b = parity of byte b                 |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module parity_gen
   import parity_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0]   data_i,
   output logic [DATA_W/8-1:0] par_o
);
   for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
      assign par_o[b] = byte_parity(data_i[8*b +: 8]);
   end
endmodule
`default_nettype wire

// File: rtl/parity_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : parity_mem                                                   |
// | Purpose : Single-port RAM storing one even-parity bit per data byte,   |
// |           with read-time parity check, uninitialised-location and     |
// |           out-of-range detection, and a saturating error counter.      |
// | Ports   : clk   - clock, rising edge                                   |
// |           reset - synchronous active-high reset                        |
// |           bus   - parity_mem_if.slave access bus                       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module parity_mem
   import parity_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned CNT_W  = 8
) (
   input  logic        clk,
   input  logic        reset,
   parity_mem_if.slave bus
);
   localparam int unsigned c_nb     = DATA_W / 8;
   localparam int unsigned c_word_w = DATA_W + c_nb;
   localparam int unsigned c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Storage: no reset, one synchronous read port (read-first).
   logic [c_word_w-1:0] mem_q [DEPTH];
   logic [c_word_w-1:0] rd_word_q;

   logic [DEPTH-1:0]    written_q;
   logic                rd_valid_q;
   logic                show_q;      // last read hit a valid, written location
   logic                uninit_q;
   logic                addr_err_q;
   logic                aerr_wr_q;   // addr_err currently set by a write
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_d;

   logic [c_idx_w-1:0]  w_idx;
   logic                w_oob;
   logic                w_wr_ok;
   logic [c_nb-1:0]     w_par_wr;
   logic [c_nb-1:0]     w_par_store;
   logic [c_nb-1:0]     w_par_chk;
   logic                w_perr;

   assign w_idx   = bus.address[c_idx_w-1:0];
   assign w_oob   = {1'b0, bus.address} >= (ADDR_W+1)'(DEPTH);
   assign w_wr_ok = bus.write & ~w_oob;

   parity_gen #(.DATA_W(DATA_W)) u_pgen_wr (
      .data_i (bus.data_in),
      .par_o  (w_par_wr)
   );

   // Error injection corrupts only parity bit 0 of the stored word.
   assign w_par_store = w_par_wr ^ c_nb'(bus.inj_err);

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (w_wr_ok) begin
            mem_q[w_idx] <= {w_par_store, bus.data_in};
         end
         if (bus.read) begin
            rd_word_q <= mem_q[w_idx];
         end
      end
   end

   parity_gen #(.DATA_W(DATA_W)) u_pgen_chk (
      .data_i (rd_word_q[DATA_W-1:0]),
      .par_o  (w_par_chk)
   );

   // Checked on the held read word, so the flag holds along with data_out.
   assign w_perr = show_q & (w_par_chk != rd_word_q[c_word_w-1:DATA_W]);

   // The increment is visible in the same cycle as the failing read result;
   // the register absorbs it on the next edge, when rd_valid has dropped.
   always_comb begin
      cnt_d = cnt_q;
      if (rd_valid_q && w_perr && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         written_q  <= '0;
         rd_valid_q <= 1'b0;
         show_q     <= 1'b0;
         uninit_q   <= 1'b0;
         addr_err_q <= 1'b0;
         aerr_wr_q  <= 1'b0;
         cnt_q      <= '0;
      end else begin
         cnt_q      <= cnt_d;
         rd_valid_q <= bus.read;
         if (w_wr_ok) begin
            written_q[w_idx] <= 1'b1;
         end
         if (bus.read) begin
            show_q     <= ~w_oob & written_q[w_idx];
            uninit_q   <= ~w_oob & ~written_q[w_idx];
            addr_err_q <= w_oob;
            aerr_wr_q  <= 1'b0;
         end else if (bus.write) begin
            addr_err_q <= w_oob;
            aerr_wr_q  <= w_oob;
         end else if (aerr_wr_q) begin
            // A rejected write flags addr_err for a single cycle only.
            addr_err_q <= 1'b0;
            aerr_wr_q  <= 1'b0;
         end
      end
   end

   assign bus.data_out   = show_q ? rd_word_q : '0;
   assign bus.rd_valid   = rd_valid_q;
   assign bus.parity_err = w_perr;
   assign bus.addr_err   = addr_err_q;
   assign bus.uninit     = uninit_q;
   assign bus.err_count  = cnt_d;
endmodule
`default_nettype wire

// File: tb/tb_parity_mem.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_parity_mem                                                |
// | Purpose : Directed self-checking bench for parity_mem (DEPTH=64,       |
// |           CNT_W=2) with a reference model feeding a scoreboard queue.  |
// | Ports   : none                                                         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_parity_mem;
   import parity_mem_pkg::*;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 16;
   localparam int unsigned DEP   = 64;
   localparam int unsigned CW    = 2;

   typedef struct packed {
      logic [8:0] data;
      logic       rv;
      logic       pe;
      logic       ae;
      logic       un;
      logic [1:0] cnt;
   } exp_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   parity_mem_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

   parity_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   word_t      m_mem [DEP];
   logic [63:0] m_wr;
   exp_t       m_out;
   logic       m_aew;
   exp_t       exp_q [$];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rst, input logic wr, input logic rd,
                       input logic [15:0] a, input logic [7:0] d, input logic inj);
      exp_t  e;
      logic  oob;
      word_t w;
      reset       = rst;
      bus.write   = wr;
      bus.read    = rd;
      bus.address = a;
      bus.data_in = d;
      bus.inj_err = inj;
      if (rst) begin
         m_out = '0;
         m_wr  = '0;
         m_aew = 1'b0;
      end else begin
         oob = (a >= 16'(DEP));
         if (rd) begin
            m_out.rv = 1'b1;
            m_aew    = 1'b0;
            m_out.ae = oob;
            if (oob || !m_wr[a[5:0]]) begin
               m_out.data = '0;
               m_out.pe   = 1'b0;
               m_out.un   = !oob;
            end else begin
               w          = m_mem[a[5:0]];
               m_out.data = w;
               m_out.pe   = ((^w.data) != w.par[0]);
               m_out.un   = 1'b0;
            end
            if (m_out.pe && m_out.cnt != 2'd3) m_out.cnt = m_out.cnt + 2'd1;
         end else begin
            m_out.rv = 1'b0;
            if (wr) begin
               m_out.ae = oob;
               m_aew    = oob;
            end else if (m_aew) begin
               m_out.ae = 1'b0;
               m_aew    = 1'b0;
            end
         end
         if (wr && !oob) begin
            m_mem[a[5:0]].data = d;
            m_mem[a[5:0]].par  = {1'b0 ^ (^d) ^ inj};
            m_wr[a[5:0]]       = 1'b1;
         end
      end
      exp_q.push_back(m_out);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("data_out",   16'(bus.data_out),   16'(e.data));
      chk("rd_valid",   16'(bus.rd_valid),   16'(e.rv));
      chk("parity_err", 16'(bus.parity_err), 16'(e.pe));
      chk("addr_err",   16'(bus.addr_err),   16'(e.ae));
      chk("uninit",     16'(bus.uninit),     16'(e.un));
      chk("err_count",  16'(bus.err_count),  16'(e.cnt));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      total = 0;
      bad   = 0;
      m_out = '0;
      m_wr  = '0;
      m_aew = 1'b0;
      reset = 1'b1;
      bus.write = 1'b0; bus.read = 1'b0; bus.address = '0;
      bus.data_in = '0; bus.inj_err = 1'b0;

      // Reset state
      step(1, 0, 0, 16'h0000, 8'h00, 0);
      step(1, 0, 0, 16'h0000, 8'h00, 0);
      chk("reset_data", 16'(bus.data_out), 16'h0000);
      chk("reset_cnt",  16'(bus.err_count), 16'h0000);

      // Plain write then read
      step(0, 1, 0, 16'h0010, 8'hA5, 0);
      step(0, 0, 1, 16'h0010, 8'h00, 0);
      chk("a5_data", 16'(bus.data_out), 16'h00A5);
      chk("a5_rv",   16'(bus.rd_valid), 16'h0001);
      step(0, 0, 0, 16'h0000, 8'h00, 0);          // hold: data stays, rv drops
      chk("a5_hold", 16'(bus.data_out), 16'h00A5);

      // Injected parity error
      step(0, 1, 0, 16'h0003, 8'h07, 1);
      step(0, 0, 1, 16'h0003, 8'h00, 0);
      chk("inj_data", 16'(bus.data_out),   16'h0007);
      chk("inj_pe",   16'(bus.parity_err), 16'h0001);
      chk("inj_cnt",  16'(bus.err_count),  16'h0001);
      step(0, 0, 0, 16'h0000, 8'h00, 0);          // count must not re-increment
      chk("inj_cnt_hold", 16'(bus.err_count), 16'h0001);

      // Never-written location after reset
      step(1, 0, 0, 16'h0000, 8'h00, 0);
      step(0, 0, 1, 16'h0020, 8'h00, 0);
      chk("uninit_flag", 16'(bus.uninit), 16'h0001);
      step(0, 0, 1, 16'h0010, 8'h00, 0);          // written before reset, now cleared
      chk("uninit_clr", 16'(bus.uninit), 16'h0001);

      // Out-of-range access at DEPTH boundary
      step(0, 1, 0, 16'h0040, 8'h55, 0);
      chk("oob_wr_ae", 16'(bus.addr_err), 16'h0001);
      step(0, 0, 0, 16'h0000, 8'h00, 0);
      chk("oob_wr_ae_pulse", 16'(bus.addr_err), 16'h0000);
      step(0, 0, 1, 16'h0040, 8'h00, 0);
      chk("oob_rd_data", 16'(bus.data_out), 16'h0000);
      chk("oob_rd_ae",   16'(bus.addr_err), 16'h0001);
      step(0, 1, 0, 16'h003F, 8'hC3, 0);          // last valid location
      step(0, 0, 1, 16'h003F, 8'h00, 0);
      step(0, 0, 1, 16'hFFFF, 8'h00, 0);

      // Read-first on same-cycle read/write
      step(0, 1, 0, 16'h0005, 8'h07, 0);
      step(0, 1, 1, 16'h0005, 8'h11, 0);
      chk("rf_old", 16'(bus.data_out), 16'h0107);
      step(0, 0, 1, 16'h0005, 8'h00, 0);
      chk("rf_new", 16'(bus.data_out), 16'h0011);

      // Counter saturation, then reset with read/write pending
      step(1, 0, 0, 16'h0000, 8'h00, 0);
      step(0, 1, 0, 16'h0003, 8'h07, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 16'h0003, 8'h00, 0);
         step(0, 0, 0, 16'h0000, 8'h00, 0);
      end
      chk("sat_cnt", 16'(bus.err_count), 16'h0003);
      step(1, 1, 1, 16'h0006, 8'h22, 0);
      chk("rst_data", 16'(bus.data_out), 16'h0000);
      chk("rst_rv",   16'(bus.rd_valid), 16'h0000);
      chk("rst_cnt",  16'(bus.err_count), 16'h0000);
      step(0, 0, 1, 16'h0006, 8'h00, 0);          // write under reset was dropped
      chk("rst_nowr", 16'(bus.uninit), 16'h0001);
      step(0, 0, 1, 16'h0003, 8'h00, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
